universal_shift_register_p: RTL
===============================

// Module: universal_shift_register_p
// PURPOSE
//  Parametrised universal shift register: WIDTH-bit hold/shift/rotate/arith-shift/load datapath.
//  Adds a burst engine that performs N back-to-back shifts from one start pulse, with busy/done.
//  Serves as general serialiser/deserialiser and barrel-lite shifter for the datapath.
// PARAMETERS
//  WIDTH    4  register width in bits, >=2
//  COUNT_W  4  width of burst count; max burst = 2**COUNT_W-1 shifts
// PORTS
//  clock        in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-high; clears all state
//  mode         in   3        operation select (see BEHAVIOUR)
//  data_in      in   WIDTH    parallel load data
//  serial_in_r  in   1        bit entering MSB on SHR
//  serial_in_l  in   1        bit entering LSB on SHL
//  start        in   1        begin burst using mode/count sampled this edge
//  count        in   COUNT_W  number of shifts in burst
//  abort        in   1        cancel running burst
//  data_out     out  WIDTH    register contents
//  serial_out_r out  1        data_out[0]
//  serial_out_l out  1        data_out[WIDTH-1]
//  busy         out  1        high while burst in RUN
//  done         out  1        one-cycle pulse, burst complete
// BEHAVIOUR
//  - Clock is clock; reset is asynchronous, active-high. Reset: data_out=0, busy=0, done=0, FSM=IDLE.
//  - mode: 000 HOLD; 001 SHR {serial_in_r,q[W-1:1]}; 010 SHL {q[W-2:0],serial_in_l};
//    011 LOAD data_in; 100 ROTR {q[0],q[W-1:1]}; 101 ROTL {q[W-2:0],q[W-1]};
//    110 ASR {q[W-1],q[W-1:1]}; 111 reserved = HOLD.
//  - FSM states IDLE, RUN, DONE (usr_state_t). rem = COUNT_W-bit remaining counter.
//  - IDLE, start=0: mode applied every edge (single-step, 1-cycle latency).
//  - IDLE, start=1 at edge k: latch mode (bmode) and rem=count; no datapath change; ->RUN.
//  - RUN: mode/data_in/start ignored; serial_in_r/l sampled live each edge.
//    rem==0: ->DONE, no shift. rem>=1: apply bmode, rem--; if rem==1 ->DONE else stay.
//    So count=N gives shifts on edges k+1..k+N; done high the cycle after edge k+N.
//  - bmode LOAD: data_in sampled at each RUN edge. HOLD/111: no change, counter still runs.
//  - DONE: done=1, busy=0, register holds; ->IDLE next edge; start in DONE ignored.
//  - busy = (state==RUN); done = (state==DONE); both registered-state decodes, glitch-free.
//  - abort: RUN->IDLE at next edge, no shift that edge, no done pulse; register keeps value.
//    abort in IDLE with start=1: abort wins, no burst, no single-step op that edge.
//    abort in IDLE without start: ignored, single-step op proceeds.
//  - Reset mid-burst: immediate clear to reset state; no done pulse.
//  - No overflow/wrap concerns: rem only counts down, stops at DONE.
// CONFIGURATION
//  - USR_PARITY_EN defined: extra output port parity (1 bit) = registered even parity of
//    next data_out value, i.e. always equals ^data_out; reset 0.
//  - USR_PARITY_EN undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  - usr_pkg: mode constants (USR_HOLD..USR_ASR), usr_state_t enum {IDLE,RUN,DONE},
//    shared next-value function usr_shift(q, mode, sin_r, sin_l, din).
//  - Sub-module usr_burst_ctrl: FSM + rem counter; outputs step_en, sel_burst, busy, done.
//  - Top: datapath register + mode mux (IDLE uses mode, RUN uses bmode).
// TESTING  (WIDTH=4 unless noted)
//  1 reset=1 mid-activity -> data_out=0000, busy=0, done=0 immediately, before next edge.
//  2 single-step: mode=001 sin_r=1 two edges from 0000 -> 1000, 1100; mode=010 sin_l=1
//    from 0000 -> 0001, 0011; mode=011 data_in=1010 -> 1010.
//  3 ROTR/ROTL/ASR from 1001: ROTR->1100, ROTL->0011, ASR->1100, ASR again->1110.
//  4 burst: load 0001, start mode=101 count=3 -> busy 3 cycles, data_out=1000, done one
//    cycle; mode/start toggled during RUN have no effect.
//  5 count=0 burst -> no shift, done one cycle after start edge; abort after 1 of 5 ROTL
//    shifts from 0001 -> 0010 held, no done, back to IDLE.
//  6 WIDTH=8, USR_PARITY_EN: SHL sin_l=1 x3 from 0 -> 00000111, parity=1; reset mid-burst clears.

Source files
------------

// File: rtl/usr_pkg.sv
// Package usr_pkg: shared definitions for the universal shift register.
// Holds the mode encodings, the burst FSM state type and the next-value
// function used by the datapath. Optional feature macro: USR_PARITY_EN.
package usr_pkg;

    // Widest register the shared next-value function can evaluate.
    localparam int USR_MAX_W = 32;

    // Operation select encodings.
    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROTR = 3'b100;
    localparam logic [2:0] USR_ROTL = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;

    // Burst engine states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } usr_state_t;

    // Next register value for one operation on a w-bit register held in
    // the low bits of q; bits at and above w are always returned as zero.
    function automatic logic [USR_MAX_W-1:0] usr_shift(
        input logic [USR_MAX_W-1:0] q,
        input logic [2:0]           mode,
        input logic                 sin_r,
        input logic                 sin_l,
        input logic [USR_MAX_W-1:0] din,
        input logic [5:0]           w
    );
        logic [USR_MAX_W-1:0] r;
        logic [USR_MAX_W-1:0] mask;
        logic [4:0]           msb;
        msb  = 5'(w - 6'd1);
        mask = ~({USR_MAX_W{1'b1}} << w);
        r    = q;
        case (mode)
            USR_SHR:  begin r = q >> 1; r[msb] = sin_r;  end
            USR_SHL:  begin r = q << 1; r[0]   = sin_l;  end
            USR_LOAD: r = din;
            USR_ROTR: begin r = q >> 1; r[msb] = q[0];   end
            USR_ROTL: begin r = q << 1; r[0]   = q[msb]; end
            USR_ASR:  begin r = q >> 1; r[msb] = q[msb]; end
            default:  r = q;   // HOLD and the reserved code
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/usr_if.sv
// Interface usr_if: control, data and status bundle of the universal
// shift register. The parity status line exists only when USR_PARITY_EN
// is defined.
interface usr_if #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
);
    logic [2:0]         mode;
    logic [WIDTH-1:0]   data_in;
    logic               serial_in_r;
    logic               serial_in_l;
    logic               start;
    logic [COUNT_W-1:0] count;
    logic               abort;
    logic [WIDTH-1:0]   data_out;
    logic               serial_out_r;
    logic               serial_out_l;
    logic               busy;
    logic               done;
`ifdef USR_PARITY_EN
    logic               parity;

    modport master (
        output mode, data_in, serial_in_r, serial_in_l, start, count, abort,
        input  data_out, serial_out_r, serial_out_l, busy, done, parity
    );

    modport slave (
        input  mode, data_in, serial_in_r, serial_in_l, start, count, abort,
        output data_out, serial_out_r, serial_out_l, busy, done, parity
    );
`else
    modport master (
        output mode, data_in, serial_in_r, serial_in_l, start, count, abort,
        input  data_out, serial_out_r, serial_out_l, busy, done
    );

    modport slave (
        input  mode, data_in, serial_in_r, serial_in_l, start, count, abort,
        output data_out, serial_out_r, serial_out_l, busy, done
    );
`endif
endinterface

// File: rtl/usr_burst_ctrl.sv
// Module usr_burst_ctrl: burst engine of the universal shift register.
// Runs the IDLE/RUN/DONE state machine and the remaining-shift counter,
// tells the datapath when to update and which mode to use.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int COUNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [2:0]         mode,
    input  logic [COUNT_W-1:0] count,
    output logic               step_en,
    output logic               sel_burst,
    output logic [2:0]         bmode,
    output logic               busy,
    output logic               done
);

    usr_state_t         state;
    logic [COUNT_W-1:0] rem;

    // Decide whether the datapath register takes a new value this edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        step_en = 1'b0;
        case (state)
            IDLE:    step_en = !start;                 // start (with or without abort) suppresses the single step
            RUN:     step_en = !abort && (rem != '0);
            default: step_en = 1'b0;
        endcase
    end

    assign sel_burst = (state == RUN);

    // Burst state machine with registered busy/done flags.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
            bmode <= USR_HOLD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !abort) begin
                        bmode <= mode;
                        rem   <= count;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rem == '0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rem <= rem - COUNT_W'(1);
                        if (rem == COUNT_W'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/universal_shift_register_p.sv
// Module universal_shift_register_p: WIDTH-bit universal shift register
// (hold/shift/rotate/arith-shift/load) with a burst engine that performs
// up to 2**COUNT_W-1 back-to-back operations from one start pulse.
// Define USR_PARITY_EN to add a registered even-parity status line.
// WIDTH must lie in 2..32.
module universal_shift_register_p #(
    parameter int WIDTH   = 4,
    parameter int COUNT_W = 4
) (
    input  logic clock,
    input  logic reset,
    usr_if.slave bus
);
    import usr_pkg::*;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] data_next;
    logic [2:0]       eff_mode;
    logic [2:0]       bmode;
    logic             step_en;
    logic             sel_burst;

    usr_burst_ctrl #(
        .COUNT_W (COUNT_W)
    ) u_burst_ctrl (
        .clock     (clock),
        .reset     (reset),
        .start     (bus.start),
        .abort     (bus.abort),
        .mode      (bus.mode),
        .count     (bus.count),
        .step_en   (step_en),
        .sel_burst (sel_burst),
        .bmode     (bmode),
        .busy      (bus.busy),
        .done      (bus.done)
    );

    // Select the live or latched burst mode and compute the next register value.
    always_comb begin
        eff_mode  = sel_burst ? bmode : bus.mode;
        shifted   = WIDTH'(usr_shift(USR_MAX_W'(data_q), eff_mode,
                                     bus.serial_in_r, bus.serial_in_l,
                                     USR_MAX_W'(bus.data_in), 6'(WIDTH)));
        data_next = step_en ? shifted : data_q;
    end

    // Datapath register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_next;
        end
    end

    assign bus.data_out     = data_q;
    assign bus.serial_out_r = data_q[0];
    assign bus.serial_out_l = data_q[WIDTH-1];

`ifdef USR_PARITY_EN
    logic parity_q;

    // Parity of the value being loaded, so it always matches data_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^data_next;
        end
    end

    assign bus.parity = parity_q;
`endif

endmodule
